btu_stream: RTL and testbench
=============================

# btu_stream

Parametrised, streaming bit-plane transpose unit for the BTU datapath. It accepts a block of NUM_WORDS elements, each `n` bits wide, and emits the `n` bit-planes of that block, ROWS_PER_BEAT planes per beat, under valid/ready backpressure. It generalises the fixed 32-word, single-shot transpose in width, depth and output rate, and adds plane ordering and an optional ping-pong input buffer.

## Interface
- NUM_WORDS, 32, elements per block and bits per output row
- DATA_WIDTH, 32, element container width and maximum legal `n`
- ROWS_PER_BEAT, 4, planes per output beat (1..DATA_WIDTH)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  input block valid
- ready_in  out  1  input block accepted when high with valid_in
- data_in  in  NUM_WORDS*DATA_WIDTH  element c in bits [c*DATA_WIDTH +: DATA_WIDTH]; only the low `n` bits are used
- n_in  in  $clog2(DATA_WIDTH+1)  element width
- msb_first_in  in  1  0: plane 0 first; 1: plane n-1 first
- valid_out  out  1  output beat valid
- ready_out  in  1  output beat consumed when high with valid_out
- rows_out  out  ROWS_PER_BEAT*NUM_WORDS  slot k in [k*NUM_WORDS +: NUM_WORDS]; bit c = bit p of element c
- row_mask_out  out  ROWS_PER_BEAT  slot k holds a real plane
- row_base_out  out  $clog2(DATA_WIDTH)  sequence index of slot 0 within the block
- last_out  out  1  final beat of the block
- err_out  out  1  one-cycle pulse: illegal `n` discarded

## Operation
- Accept on valid_in && ready_in: data, n_in and msb_first_in are latched into a buffer.
- Beats per block = ceil(n/ROWS_PER_BEAT). Slot k of beat b carries sequence index s = b*ROWS_PER_BEAT+k. The plane p is s when msb_first=0, and n-1-s when msb_first=1.
- On the final beat, row_mask_out has the low (n − b*ROWS_PER_BEAT) bits set. Unused slots are zero. All other beats have an all-ones mask.
- Illegal width: n_in==0 or n_in>DATA_WIDTH.
  - The block is accepted and discarded.
  - err_out pulses in the next cycle.
  - No beat is produced and state is unchanged.
- FSM per buffer: EMPTY → (accept) FULL → (first beat presented) STREAM → (last beat handshake) EMPTY.
- A beat counter advances only on valid_out && ready_out.
- rows_out, row_mask_out, row_base_out and last_out are driven to 0 whenever valid_out=0.

## Timing
- Reset values:
  - valid_out=0, err_out=0, all data outputs 0.
  - ready_in=1 during and after reset.
  - Buffers are marked empty.
  - Beat counter is 0.
- Latency: a block accepted at edge T presents its first beat from cycle T+1 (valid_out high after edge T).
- While valid_out && !ready_out, all outputs hold stable.
- Ready behaviour:
  - ready_in does not depend on valid_in.
  - ready_out may toggle freely.
- Reset mid-block: everything in flight is dropped, and no partial beat appears after reset.
- Simultaneous last-beat handshake and accept: see Configuration.

## Configuration
- BTU_STREAM_PINGPONG_EN defined:
  - Two buffers, used alternately.
  - ready_in=1 while at least one buffer is empty.
  - A last-beat handshake in the same cycle as an accept frees the streaming buffer, and the other buffer's first beat follows in the next cycle with no bubble.
  - Blocks are emitted strictly in acceptance order.
- Undefined:
  - One buffer.
  - ready_in=1 only when that buffer is empty.
  - Between back-to-back blocks there is exactly one idle output cycle: the accept cycle after the last beat.

## Structure
- btu_pkg gains:
  - default constants BTU_STREAM_NUM_WORDS, BTU_STREAM_DATA_WIDTH, BTU_STREAM_ROWS_PER_BEAT
  - function btu_num_beats(n, rows_per_beat)
  - a buffer-state enum (EMPTY, FULL, STREAM)
- One combinational sub-module, btu_plane_sel. Inputs: one buffer, n, msb_first and beat base. Outputs: rows_out, row_mask_out, last_out.
- btu_stream holds the buffers, FSM, counters and handshake.

## Test plan
All scenarios use defaults (32/32/4) and element c = c.
- n=5, msb_first=0, ready_out=1:
  - beat 0 rows 0xAAAAAAAA, 0xCCCCCCCC, 0xF0F0F0F0, 0xFF00FF00, mask 4'b1111, base 0.
  - beat 1 row0 0xFFFF0000, mask 4'b0001, base 4, last=1.
- n=5, msb_first=1:
  - beat 0 rows 0xFFFF0000, 0xFF00FF00, 0xF0F0F0F0, 0xCCCCCCCC.
  - beat 1 row0 0xAAAAAAAA, mask 4'b0001, last=1.
- n=8 with ready_out low for 3 cycles after beat 0 is presented: beat 0 outputs hold bit-identical, then beat 1 (last) follows. Total 2 handshakes, no loss or duplication.
- Two n=8 blocks offered back-to-back, ready_out=1:
  - with BTU_STREAM_PINGPONG_EN: 4 beats on 4 consecutive cycles.
  - without it: 4 beats with exactly one valid_out=0 cycle between blocks.
- n_in=0, then n_in=33: err_out pulses once per block, valid_out stays 0, ready_in=1 throughout.
- rst asserted on beat 1 of an n=16 block: valid_out=0 immediately. After release a new n=4 block produces a single beat with base 0 and last=1.

Source files
------------

// File: rtl/btu_pkg.sv
// Shared constants, buffer states and helpers for the BTU bit-plane transpose stream.
package btu_pkg;

    localparam int BTU_STREAM_NUM_WORDS     = 32;
    localparam int BTU_STREAM_DATA_WIDTH    = 32;
    localparam int BTU_STREAM_ROWS_PER_BEAT = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } btu_buf_state_e;

    function automatic int btu_num_beats(input int n, input int rows_per_beat);
        return (n + rows_per_beat - 1) / rows_per_beat;
    endfunction

endpackage

// File: rtl/btu_plane_sel.sv
// Combinational bit-plane selector: builds one output beat of ROWS_PER_BEAT planes
// from a stored block, its element width, plane ordering and beat base index.
module btu_plane_sel
    import btu_pkg::*;
#(
    parameter int NUM_WORDS     = BTU_STREAM_NUM_WORDS,
    parameter int DATA_WIDTH    = BTU_STREAM_DATA_WIDTH,
    parameter int ROWS_PER_BEAT = BTU_STREAM_ROWS_PER_BEAT,
    localparam int NW = $clog2(DATA_WIDTH + 1),
    localparam int BW = $clog2(DATA_WIDTH)
) (
    input  logic [NUM_WORDS*DATA_WIDTH-1:0]  buf_i,
    input  logic [NW-1:0]                    n_i,
    input  logic                             msb_first_i,
    input  logic [BW-1:0]                    base_i,
    output logic [ROWS_PER_BEAT*NUM_WORDS-1:0] rows_o,
    output logic [ROWS_PER_BEAT-1:0]         row_mask_o,
    output logic                             last_o
);

    logic [DATA_WIDTH-1:0] elem;
    logic [BW-1:0]         plane;
    int                    seq;

    // NOTE: every output and temporary gets a default first, so no path leaves them unassigned (no latches).
    always_comb begin
        rows_o     = '0;
        row_mask_o = '0;
        elem       = '0;
        plane      = '0;
        seq        = 0;
        for (int k = 0; k < ROWS_PER_BEAT; k++) begin
            seq = int'(base_i) + k;
            if (seq < int'(n_i)) begin
                row_mask_o[k] = 1'b1;
                plane = msb_first_i ? BW'(int'(n_i) - 1 - seq) : BW'(seq);
                for (int c = 0; c < NUM_WORDS; c++) begin
                    elem = buf_i[c*DATA_WIDTH +: DATA_WIDTH];
                    rows_o[k*NUM_WORDS + c] = elem[plane];
                end
            end
        end
        last_o = (int'(base_i) / ROWS_PER_BEAT + 1) >= btu_num_beats(int'(n_i), ROWS_PER_BEAT);
    end

endmodule

// File: rtl/btu_stream.sv
// Streaming bit-plane transpose unit with valid/ready on both sides.
// Define BTU_STREAM_PINGPONG_EN for a two-entry ping-pong input buffer.
module btu_stream
    import btu_pkg::*;
#(
    parameter int NUM_WORDS     = BTU_STREAM_NUM_WORDS,
    parameter int DATA_WIDTH    = BTU_STREAM_DATA_WIDTH,
    parameter int ROWS_PER_BEAT = BTU_STREAM_ROWS_PER_BEAT,
    localparam int NW = $clog2(DATA_WIDTH + 1),
    localparam int BW = $clog2(DATA_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    output logic                               ready_in,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0]    data_in,
    input  logic [NW-1:0]                      n_in,
    input  logic                               msb_first_in,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic [ROWS_PER_BEAT*NUM_WORDS-1:0] rows_out,
    output logic [ROWS_PER_BEAT-1:0]           row_mask_out,
    output logic [BW-1:0]                      row_base_out,
    output logic                               last_out,
    output logic                               err_out
);

`ifdef BTU_STREAM_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    btu_buf_state_e                  state_q [NBUF];
    logic [NUM_WORDS*DATA_WIDTH-1:0] data_q  [NBUF];
    logic [NW-1:0]                   n_q     [NBUF];
    logic                            msb_q   [NBUF];
    logic                            wr_sel_q;
    logic                            rd_sel_q;
    logic [BW-1:0]                   beat_q;
    logic                            err_q;

    btu_buf_state_e                  cur_state;
    logic [NUM_WORDS*DATA_WIDTH-1:0] cur_data;
    logic [NW-1:0]                   cur_n;
    logic                            cur_msb;
    logic                            any_empty;
    logic                            accept;
    logic                            n_legal;
    logic                            store;
    logic                            fire;
    logic [BW-1:0]                   base;
    logic [ROWS_PER_BEAT*NUM_WORDS-1:0] sel_rows;
    logic [ROWS_PER_BEAT-1:0]        sel_mask;
    logic                            sel_last;

    always_comb begin
        any_empty = 1'b0;
        for (int i = 0; i < NBUF; i++) begin
            if (state_q[i] == EMPTY) any_empty = 1'b1;
        end
    end

    assign ready_in = any_empty;
    assign accept   = valid_in && ready_in;
    assign n_legal  = (n_in != '0) && (int'(n_in) <= DATA_WIDTH);
    assign store    = accept && n_legal;

    // Output side always reads the oldest occupied buffer.
    always_comb begin
        cur_state = EMPTY;
        cur_data  = '0;
        cur_n     = '0;
        cur_msb   = 1'b0;
        for (int i = 0; i < NBUF; i++) begin
            if (int'(rd_sel_q) == i) begin
                cur_state = state_q[i];
                cur_data  = data_q[i];
                cur_n     = n_q[i];
                cur_msb   = msb_q[i];
            end
        end
    end

    assign valid_out = (cur_state != EMPTY);
    assign fire      = valid_out && ready_out;
    assign base      = BW'(int'(beat_q) * ROWS_PER_BEAT);

    btu_plane_sel #(
        .NUM_WORDS     (NUM_WORDS),
        .DATA_WIDTH    (DATA_WIDTH),
        .ROWS_PER_BEAT (ROWS_PER_BEAT)
    ) u_plane_sel (
        .buf_i       (cur_data),
        .n_i         (cur_n),
        .msb_first_i (cur_msb),
        .base_i      (base),
        .rows_o      (sel_rows),
        .row_mask_o  (sel_mask),
        .last_o      (sel_last)
    );

    assign rows_out     = valid_out ? sel_rows : '0;
    assign row_mask_out = valid_out ? sel_mask : '0;
    assign row_base_out = valid_out ? base     : '0;
    assign last_out     = valid_out && sel_last;
    assign err_out      = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) state_q[i] <= EMPTY;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && !n_legal;
            if (fire) beat_q <= sel_last ? '0 : beat_q + 1'b1;
            for (int i = 0; i < NBUF; i++) begin
                if (store && int'(wr_sel_q) == i) begin
                    state_q[i] <= FULL;
                end else if (int'(rd_sel_q) == i) begin
                    case (state_q[i])
                        FULL, STREAM: begin
                            if (fire && sel_last) state_q[i] <= EMPTY;
                            else                  state_q[i] <= STREAM;
                        end
                        default: ;
                    endcase
                end
            end
            if (NBUF > 1) begin
                if (store)             wr_sel_q <= ~wr_sel_q;
                if (fire && sel_last)  rd_sel_q <= ~rd_sel_q;
            end
        end
    end

    // NOTE: block storage has no reset; the buffer state gates every output, so stale contents never escape.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBUF; i++) begin
            if (store && int'(wr_sel_q) == i) begin
                data_q[i] <= data_in;
                n_q[i]    <= n_in;
                msb_q[i]  <= msb_first_in;
            end
        end
    end

endmodule

// File: tb/tb_btu_stream.sv
// Scoreboard bench for btu_stream: directed plan scenarios plus randomized blocks and backpressure.
`timescale 1ns/1ps
module tb_btu_stream;
    import btu_pkg::*;

    localparam int NWD = BTU_STREAM_NUM_WORDS;
    localparam int DW  = BTU_STREAM_DATA_WIDTH;
    localparam int RPB = BTU_STREAM_ROWS_PER_BEAT;
    localparam int NB  = $clog2(DW + 1);
    localparam int BW  = $clog2(DW);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 ready_in;
    logic [NWD*DW-1:0]    data_in = '0;
    logic [NB-1:0]        n_in = '0;
    logic                 msb_first_in = 1'b0;
    logic                 valid_out;
    logic                 ready_out = 1'b0;
    logic [RPB*NWD-1:0]   rows_out;
    logic [RPB-1:0]       row_mask_out;
    logic [BW-1:0]        row_base_out;
    logic                 last_out;
    logic                 err_out;

    always #5 clk = ~clk;

    btu_stream dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .data_in      (data_in),
        .n_in         (n_in),
        .msb_first_in (msb_first_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .rows_out     (rows_out),
        .row_mask_out (row_mask_out),
        .row_base_out (row_base_out),
        .last_out     (last_out),
        .err_out      (err_out)
    );

    typedef struct {
        logic [RPB*NWD-1:0] rows;
        logic [RPB-1:0]     mask;
        logic [BW-1:0]      base;
        logic               last;
    } beat_t;

    beat_t       exp_q[$];
    int          hs_cycles[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycle    = 0;
    int          err_seen = 0;
    int          err_exp  = 0;
    logic [31:0] blk [NWD];
    bit          rand_ready  = 1'b0;
    logic        ready_fixed = 1'b1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(posedge clk) cycle++;

    always @(posedge clk) begin
        #2;
        ready_out = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    // Monitor: hold-stability, idle-zero and in-order beat comparison against the scoreboard.
    bit                 stalled = 1'b0;
    logic [RPB*NWD-1:0] h_rows;
    logic [RPB-1:0]     h_mask;
    logic [BW-1:0]      h_base;
    logic               h_last;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (err_out) err_seen++;
            if (stalled)
                check("hold_stable", {valid_out, rows_out, row_mask_out, row_base_out, last_out},
                      {1'b1, h_rows, h_mask, h_base, h_last});
            if (!valid_out)
                check("idle_zero", {rows_out, row_mask_out, row_base_out, last_out}, '0);
            if (valid_out && ready_out) begin
                hs_cycles.push_back(cycle);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got base %0d rows %h, expected no beat", row_base_out, rows_out);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_rows", rows_out, e.rows);
                    check("beat_mask", row_mask_out, e.mask);
                    check("beat_base", row_base_out, e.base);
                    check("beat_last", last_out, e.last);
                end
            end
            stalled = valid_out && !ready_out;
            h_rows = rows_out;
            h_mask = row_mask_out;
            h_base = row_base_out;
            h_last = last_out;
        end
    end

    // Reference model: plane p of a block is bit p of every element, in sequence order.
    task automatic push_model(input int n, input bit msb);
        int    beats;
        int    s;
        int    p;
        beat_t e;
        beats = (n + RPB - 1) / RPB;
        for (int b = 0; b < beats; b++) begin
            e.rows = '0;
            e.mask = '0;
            e.base = BW'(b * RPB);
            e.last = (b == beats - 1);
            for (int k = 0; k < RPB; k++) begin
                s = b * RPB + k;
                if (s < n) begin
                    p = msb ? (n - 1 - s) : s;
                    e.mask[k] = 1'b1;
                    for (int c = 0; c < NWD; c++) e.rows[k*NWD + c] = blk[c][p];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_beat(input logic [RPB*NWD-1:0] rows, input logic [RPB-1:0] mask,
                             input int base, input bit last);
        beat_t e;
        e.rows = rows;
        e.mask = mask;
        e.base = BW'(base);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Offers blk; returns at posedge+1 after the accepting edge.
    task automatic send_block(input int n, input bit msb, input bit use_model);
        int waited;
        bit got;
        bit legal;
        legal = (n >= 1) && (n <= DW);
        for (int c = 0; c < NWD; c++) data_in[c*DW +: DW] = blk[c];
        n_in         = NB'(n);
        msb_first_in = msb;
        valid_in     = 1'b1;
        waited       = 0;
        got          = 1'b0;
        while (!got && waited < 500) begin
            @(negedge clk);
            if (ready_in) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout: ready_in low for %0d cycles, expected 1", waited);
        end else if (!legal) begin
            err_exp++;
        end else if (use_model) begin
            push_model(n, msb);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (got && !legal) check("err_pulse", err_out, 1'b1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int h0;
        int gap_ok;
        int n;

        for (int c = 0; c < NWD; c++) blk[c] = c;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_err_out", err_out, 1'b0);
        check("rst_ready_in", ready_in, 1'b1);
        check("rst_data_outs", {rows_out, row_mask_out, row_base_out, last_out}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready_in", ready_in, 1'b1);

        // n=5, plane 0 first
        push_beat({32'hFF00FF00, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA}, 4'b1111, 0, 1'b0);
        push_beat({96'h0, 32'hFFFF0000}, 4'b0001, 4, 1'b1);
        send_block(5, 1'b0, 1'b0);
        check("latency_valid", valid_out, 1'b1);
        wait_drain();

        // n=5, plane n-1 first
        push_beat({32'hCCCCCCCC, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFF0000}, 4'b1111, 0, 1'b0);
        push_beat({96'h0, 32'hAAAAAAAA}, 4'b0001, 4, 1'b1);
        send_block(5, 1'b1, 1'b0);
        wait_drain();

        // n=8 with the consumer stalled after the first beat appears
        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        h0 = hs_cycles.size();
        send_block(8, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stall_no_early_hs", hs_cycles.size() - h0, 0);
        ready_fixed = 1'b1;
        wait_drain();
        check("stall_handshakes", hs_cycles.size() - h0, 2);

        // Two n=8 blocks back to back
        h0 = hs_cycles.size();
        send_block(8, 1'b0, 1'b1);
        send_block(8, 1'b1, 1'b1);
        wait_drain();
        check("b2b_handshakes", hs_cycles.size() - h0, 4);
        if (hs_cycles.size() - h0 == 4) begin
            gap_ok = ((hs_cycles[h0+1] - hs_cycles[h0]) == 1) && ((hs_cycles[h0+3] - hs_cycles[h0+2]) == 1);
            check("b2b_in_block_gap", gap_ok, 1);
`ifdef BTU_STREAM_PINGPONG_EN
            check("b2b_between_gap", hs_cycles[h0+2] - hs_cycles[h0+1], 1);
`else
            check("b2b_between_gap", hs_cycles[h0+2] - hs_cycles[h0+1], 2);
`endif
        end

        // Illegal widths
        send_block(0, 1'b0, 1'b1);
        send_block(33, 1'b0, 1'b1);
        repeat (3) begin
            check("illegal_no_valid", valid_out, 1'b0);
            check("illegal_ready_in", ready_in, 1'b1);
            @(posedge clk);
            #1;
        end

        // Reset while beat 1 of an n=16 block is presented
        send_block(16, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_beat1_base", row_base_out, BW'(4));
        rst = 1'b1;
        #1;
        check("mid_rst_valid_out", valid_out, 1'b0);
        check("mid_rst_data_outs", {rows_out, row_mask_out, row_base_out, last_out}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst2_valid_out", valid_out, 1'b0);
        send_block(4, 1'b0, 1'b1);
        check("single_beat_base", row_base_out, '0);
        check("single_beat_last", last_out, 1'b1);
        wait_drain();

        // Randomized blocks under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < NWD; c++) blk[c] = $urandom;
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DW + 1, 63);
            else n = $urandom_range(1, DW);
            send_block(n, $urandom_range(0, 1) == 1, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("err_pulse_count", err_seen, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
